// File: rtl/uart_tx_arb_if.sv
// Requester-side byte bus for uart_tx_arb: one valid/ready/last/byte lane per requester.
interface uart_tx_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N-1:0][7:0] req_byte;
  logic [N-1:0]      req_ready;

  modport master (output req_valid, output req_last, output req_byte, input req_ready);
  modport slave  (input req_valid, input req_last, input req_byte, output req_ready);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N byte requesters, with frame locking
// and a watchdog on the uart_tx acknowledge (tx_empty falling after the write strobe).

// Per-requester ready cell: a lane is ready only when it is the selected winner.
module uart_tx_arb_lane #(
  parameter int ID = 0,
  parameter int IW = 2
) (
  input  logic          go,
  input  logic [IW-1:0] win,
  input  logic          valid,
  output logic          ready
);
  assign ready = go && valid && (win == IW'(ID));
endmodule

module uart_tx_arb #(
  parameter int N           = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arb_if.slave         req,
  input  logic                 tx_empty,
  output logic                 tx_wr_en,
  output logic [7:0]           tx_byte,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 locked,
  output logic                 busy,
  output logic                 err
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, WAIT_LOW, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic          tx_wr_en_q, tx_wr_en_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] win;
  logic [IW-1:0] j_idx;
  logic          win_vld;
  logic          arb_go;
  logic [N-1:0]  ready_w;

  // Ready is combinational, so it is also gated by reset to read idle while rst is held low.
  assign arb_go = rst && (state_q == ARB) && tx_empty;

  // Winner: the lock owner alone while locked, otherwise first valid after the pointer.
  always_comb begin
    win     = grant_q;
    win_vld = 1'b0;
    j_idx   = '0;
    if (locked_q) begin
      win_vld = req.req_valid[grant_q];
    end else begin
      for (int k = 1; k <= N; k++) begin
        j_idx = IW'((int'(ptr_q) + k) % N);
        if (!win_vld && req.req_valid[j_idx]) begin
          win     = j_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    uart_tx_arb_lane #(.ID(g), .IW(IW)) u_lane (
      .go    (arb_go),
      .win   (win),
      .valid (req.req_valid[g]),
      .ready (ready_w[g])
    );
  end
  assign req.req_ready = ready_w;

  // Next-state: accept in ARB, then wait for uart_tx to go busy and come back idle.
  always_comb begin
    state_d    = state_q;
    tx_wr_en_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      ARB: begin
        if (arb_go && win_vld) begin
          tx_byte_d  = req.req_byte[win];
          grant_d    = win;
          ptr_d      = win;
          locked_d   = ~req.req_last[win];
          tx_wr_en_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!tx_empty) begin
          state_d = WAIT_HIGH;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // uart_tx never took the byte: flag it and drop it, no retry.
          err_d   = 1'b1;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (tx_empty) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // State register; pointer resets to N-1 so requester 0 is scanned first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      tx_wr_en_q <= 1'b0;
      tx_byte_q  <= '0;
      grant_q    <= '0;
      ptr_q      <= IW'(N - 1);
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_byte_q  <= tx_byte_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_wr_en = tx_wr_en_q;
  assign tx_byte  = tx_byte_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;
  assign busy     = (state_q != ARB);
  assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-requester source queues, a uart_tx stub for tx_empty,
// and a scoreboard of expected (byte, grant, locked) per write strobe.
module tb_uart_tx_arb;
  localparam int N    = 4;
  localparam int ACK  = 4;
  localparam int CHAR = 6;

  typedef struct packed { logic [7:0] b; logic l; } src_t;
  typedef struct packed { logic [7:0] b; logic [1:0] g; logic k; } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_empty = 1'b1;
  logic       tx_wr_en, locked, busy, err;
  logic [7:0] tx_byte;
  logic [1:0] grant_id;

  src_t         src_q[N][$];
  ev_t          exp_q[$];
  ev_t          obs_q[$];
  logic [N-1:0] hs = '0;
  bit           stub_stuck = 1'b0;
  int           stub_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  uart_tx_arb_if #(.N(N)) rq ();

  uart_tx_arb #(.N(N), .ACK_TIMEOUT(ACK)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (rq),
    .tx_empty (tx_empty),
    .tx_wr_en (tx_wr_en),
    .tx_byte  (tx_byte),
    .grant_id (grant_id),
    .locked   (locked),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // uart_tx stub: busy for CHAR cycles starting the cycle after a strobe, unless stuck idle
  always @(posedge clk) begin
    if (tx_wr_en && !stub_stuck) begin
      tx_empty <= 1'b0;
      stub_cnt <= CHAR;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) tx_empty <= 1'b1;
    end
  end

  // monitor: every write strobe is one character on the line
  always @(negedge clk) begin
    if (rst && tx_wr_en) obs_q.push_back({tx_byte, grant_id, locked});
  end

  // requester driver: present queue heads, pop on handshake
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        rq.req_valid[i] = 1'b1;
        rq.req_byte[i]  = src_q[i][0].b;
        rq.req_last[i]  = src_q[i][0].l;
      end else begin
        rq.req_valid[i] = 1'b0;
        rq.req_byte[i]  = 8'h00;
        rq.req_last[i]  = 1'b0;
      end
    end
    #1 hs = rst ? (rq.req_valid & rq.req_ready) : '0;
  end

  task automatic push(input int i, input logic [7:0] b, input logic l);
    src_q[i].push_back({b, l});
  endtask

  task automatic expect_ev(input logic [7:0] b, input logic [1:0] g, input logic k);
    exp_q.push_back({b, g, k});
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin @(negedge clk); c++; end
    while (busy && c < budget) begin @(negedge clk); c++; end
    ok = (obs_q.size() >= n) && !busy;
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    obs_q.delete();
    stub_stuck = 1'b0;
    repeat (3) @(negedge clk);
    while (!tx_empty && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_drain: tx_empty=%b want 1", tx_empty); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({tx_wr_en, tx_byte, rq.req_ready, grant_id, locked, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_vals: wr=%b byte=%h rdy=%b gid=%0d lck=%b busy=%b err=%b want all 0",
               tx_wr_en, tx_byte, rq.req_ready, grant_id, locked, busy, err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    int rdy_n = 0, wr_n = 0, rdy_first = -1, wr_first = -1, other = 0;
    ev_t e, o;
    do_reset();
    @(posedge clk); #2;
    push(0, 8'hA5, 1'b1);
    expect_ev(8'hA5, 2'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #2;
      if (rq.req_ready[0]) begin rdy_n++; if (rdy_first < 0) rdy_first = c; end
      if (rq.req_ready[N-1:1] != '0) other++;
      if (tx_wr_en) begin wr_n++; if (wr_first < 0) wr_first = c; end
    end
    checks++;
    if (rdy_n != 1) begin errors++; $display("FAIL single_ready_len: %0d cycles want 1", rdy_n); end
    checks++;
    if (wr_n != 1) begin errors++; $display("FAIL single_wr_len: %0d cycles want 1", wr_n); end
    checks++;
    if (wr_first != rdy_first + 1) begin
      errors++; $display("FAIL single_wr_lat: wr at %0d ready at %0d want wr=ready+1", wr_first, rdy_first);
    end
    checks++;
    if (other != 0) begin errors++; $display("FAIL single_other_ready: %0d cycles want 0", other); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL single_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    ev_t e, o;
    do_reset();
    @(posedge clk); #2;
    push(0, 8'h10, 1'b1); push(0, 8'h50, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    expect_ev(8'h10, 2'd0, 1'b0); expect_ev(8'h20, 2'd1, 1'b0); expect_ev(8'h30, 2'd2, 1'b0);
    expect_ev(8'h40, 2'd3, 1'b0); expect_ev(8'h50, 2'd0, 1'b0);
    wait_obs(5, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d bytes want 5", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rr_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL rr_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  task automatic test_lock();
    bit ok;
    ev_t e, o;
    do_reset();
    @(posedge clk); #2;
    push(1, 8'h01, 1'b0); push(1, 8'h02, 1'b0); push(1, 8'h03, 1'b1);
    push(2, 8'h99, 1'b1);
    expect_ev(8'h01, 2'd1, 1'b1); expect_ev(8'h02, 2'd1, 1'b1);
    expect_ev(8'h03, 2'd1, 1'b0); expect_ev(8'h99, 2'd2, 1'b0);
    wait_obs(4, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lock_timeout: got %0d bytes want 4", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL lock_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL lock_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  task automatic test_lock_idle();
    bit ok;
    do_reset();
    @(posedge clk); #2;
    push(1, 8'h0A, 1'b0);
    push(2, 8'h0B, 1'b1);
    wait_obs(1, 100, ok);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL idle_count: %0d bytes want 1", obs_q.size()); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL idle_locked: %b want 1", locked); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: %b want 0", busy); end
    checks++;
    if (rq.req_ready !== '0) begin errors++; $display("FAIL idle_ready: %b want 0", rq.req_ready); end
    checks++;
    if (obs_q.size() > 0 && obs_q[0] !== ev_t'({8'h0A, 2'd1, 1'b1})) begin
      errors++; $display("FAIL idle_seq: b=%h g=%0d l=%b want b=0a g=1 l=1", obs_q[0].b, obs_q[0].g, obs_q[0].k);
    end
  endtask

  task automatic test_reset_midframe();
    int c = 0;
    bit ok;
    ev_t e, o;
    do_reset();
    @(posedge clk); #2;
    push(1, 8'h01, 1'b0); push(1, 8'h02, 1'b0);
    push(2, 8'h99, 1'b1);
    expect_ev(8'h01, 2'd1, 1'b1); expect_ev(8'h02, 2'd1, 1'b1);
    while (obs_q.size() < 2 && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, locked, tx_empty} !== 3'b110) begin
      errors++; $display("FAIL mid_pre: busy=%b locked=%b tx_empty=%b want 1 1 0", busy, locked, tx_empty);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx_wr_en, tx_byte, rq.req_ready, grant_id, locked, busy, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_vals: wr=%b byte=%h rdy=%b gid=%0d lck=%b busy=%b err=%b want all 0",
               tx_wr_en, tx_byte, rq.req_ready, grant_id, locked, busy, err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL mid_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL mid_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
    obs_q.delete();
    src_q[2].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    push(3, 8'h33, 1'b1);
    push(0, 8'h44, 1'b1);
    expect_ev(8'h44, 2'd0, 1'b0); expect_ev(8'h33, 2'd3, 1'b0);
    wait_obs(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_timeout: got %0d bytes want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL mid_after: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL mid_after: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  task automatic test_timeout();
    int c = 0, n = 0;
    bit ok;
    ev_t e, o;
    do_reset();
    stub_stuck = 1'b1;
    @(posedge clk); #2;
    push(0, 8'h5A, 1'b1);
    expect_ev(8'h5A, 2'd0, 1'b0);
    while (!tx_wr_en && c < 20) begin @(negedge clk); #2; c++; end
    checks++;
    if (tx_wr_en !== 1'b1) begin errors++; $display("FAIL to_strobe: wr_en=%b want 1", tx_wr_en); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: err=%b want 0", err); end
    while (!err && n < 20) begin @(negedge clk); #2; n++; end
    checks++;
    if (n != ACK) begin errors++; $display("FAIL to_delay: err after %0d cycles want %0d", n, ACK); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_state: busy=%b want 0", busy); end
    stub_stuck = 1'b0;
    @(posedge clk); #2;
    push(2, 8'h66, 1'b1);
    expect_ev(8'h66, 2'd2, 1'b0);
    wait_obs(2, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_recover: got %0d bytes want 2", obs_q.size()); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL to_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL to_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ev_t e, o;
    do_reset();
    @(posedge clk); #2;
    push(3, 8'h11, 1'b1);
    push(0, 8'h22, 1'b1);
    expect_ev(8'h22, 2'd0, 1'b0); expect_ev(8'h11, 2'd3, 1'b0);
    wait_obs(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d bytes want 2", obs_q.size()); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: err=%b want 0", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_seq: none, want b=%h", e.b); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++;
          $display("FAIL b2b_seq: b=%h g=%0d l=%b want b=%h g=%0d l=%b", o.b, o.g, o.k, e.b, e.g, e.k); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_lock_idle();
    test_reset_midframe();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
